// File: rtl/int_mult_pkg.sv
// Shared constants and helpers for the integer multiplier issue path.
// Requester ids, default geometry and result-width calculation.
package int_mult_pkg;

    localparam int NUM_REQ = 2;

    localparam logic REQ_ID_0 = 1'b0;
    localparam logic REQ_ID_1 = 1'b1;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_STAGES = 5;
    localparam int DEF_TAG_WIDTH  = 4;

    function automatic int res_width(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/int_mult_rr_arb.sv
// Two-way round-robin arbiter for the multiplier input port.
// Ties go away from the last winner; winner recorded on take only.
module int_mult_rr_arb
    import int_mult_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic last_q;
    logic last_d;

    // Lone requester wins; a tie goes to the one that lost last time.
    always_comb begin
        grant_o = '0;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11: begin
                if (last_q == REQ_ID_0) begin
                    grant_o = 2'b10;
                end else begin
                    grant_o = 2'b01;
                end
            end
            default: grant_o = '0;
        endcase
    end

    // Remember the winner only when its operation is actually taken.
    always_comb begin
        last_d = last_q;
        if (advance_i && (|grant_o)) begin
            last_d = grant_o[1] ? REQ_ID_1 : REQ_ID_0;
        end
    end

    // Out of reset requester 1 counts as last winner, so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_ID_1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/int_mult_issue_ctrl.sv
// Issue controller for the pipelined integer multiplier core.
// Arbitrates two requesters and tracks in-flight ops against core latency.
module int_mult_issue_ctrl
    import int_mult_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             req0_valid,
    output logic                             req0_ready,
    input  logic [DATA_WIDTH-1:0]            req0_a,
    input  logic [DATA_WIDTH-1:0]            req0_b,
    input  logic [TAG_WIDTH-1:0]             req0_tag,
    input  logic                             req1_valid,
    output logic                             req1_ready,
    input  logic [DATA_WIDTH-1:0]            req1_a,
    input  logic [DATA_WIDTH-1:0]            req1_b,
    input  logic [TAG_WIDTH-1:0]             req1_tag,
    output logic                             mult_en,
    output logic [DATA_WIDTH-1:0]            mult_a,
    output logic [DATA_WIDTH-1:0]            mult_b,
    input  logic [res_width(DATA_WIDTH)-1:0] mult_result,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic                             res_id,
    output logic [TAG_WIDTH-1:0]             res_tag,
    output logic [res_width(DATA_WIDTH)-1:0] res_data,
    output logic                             busy
);

    logic [NUM_STAGES-1:0]                v_q;
    logic [NUM_STAGES-1:0]                v_d;
    logic [NUM_STAGES-1:0]                id_q;
    logic [NUM_STAGES-1:0]                id_d;
    logic [NUM_STAGES-1:0][TAG_WIDTH-1:0] tag_q;
    logic [NUM_STAGES-1:0][TAG_WIDTH-1:0] tag_d;

    logic [NUM_REQ-1:0]   arb_valid;
    logic [NUM_REQ-1:0]   grant;
    logic                 fire;
    logic                 gnt_id;
    logic [TAG_WIDTH-1:0] gnt_tag;

    assign res_valid = v_q[NUM_STAGES-1];
    assign res_id    = id_q[NUM_STAGES-1];
    assign res_tag   = tag_q[NUM_STAGES-1];
    assign res_data  = mult_result;
    assign busy      = |v_q;

    // Whole pipe freezes while a result waits on the consumer.
    assign mult_en = !(res_valid && !res_ready);

    // A flush cycle offers nothing to the arbiter.
    assign arb_valid = {req1_valid, req0_valid} & {NUM_REQ{!flush}};

    assign req0_ready = mult_en && !flush && grant[0];
    assign req1_ready = mult_en && !flush && grant[1];

    assign fire = req0_ready || req1_ready;

    int_mult_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (arb_valid),
        .advance_i (fire),
        .grant_o   (grant)
    );

    // Steer the granted requester's operands and identity to the core.
    always_comb begin
        mult_a  = '0;
        mult_b  = '0;
        gnt_id  = REQ_ID_0;
        gnt_tag = '0;
        unique case (1'b1)
            grant[0]: begin
                mult_a  = req0_a;
                mult_b  = req0_b;
                gnt_id  = REQ_ID_0;
                gnt_tag = req0_tag;
            end
            grant[1]: begin
                mult_a  = req1_a;
                mult_b  = req1_b;
                gnt_id  = REQ_ID_1;
                gnt_tag = req1_tag;
            end
            default: ;
        endcase
    end

    // Tracking pipe mirrors the core: shift on enable, kill all on flush.
    always_comb begin
        v_d   = v_q;
        id_d  = id_q;
        tag_d = tag_q;
        if (mult_en) begin
            v_d[0]   = fire;
            id_d[0]  = gnt_id;
            tag_d[0] = gnt_tag;
            for (int i = 1; i < NUM_STAGES; i++) begin
                v_d[i]   = v_q[i-1];
                id_d[i]  = id_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
        end
        if (flush) begin
            v_d = '0;
        end
    end

    // In-flight state register; reset drops everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            id_q  <= '0;
            tag_q <= '0;
        end else begin
            v_q   <= v_d;
            id_q  <= id_d;
            tag_q <= tag_d;
        end
    end

endmodule

// File: tb/tb_int_mult_issue_ctrl.sv
// Scoreboard bench for int_mult_issue_ctrl with a behavioural core.
// Directed scenarios: contention, single op, bubbles, stall, flush, reset.
module tb_int_mult_issue_ctrl;

    localparam int DW = 32;
    localparam int NS = 5;
    localparam int TW = 4;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [TW-1:0] tag;
    } op_t;

    typedef struct {
        logic          id;
        logic [TW-1:0] tag;
        logic [63:0]   data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic req0_valid, req0_ready;
    logic [DW-1:0] req0_a, req0_b;
    logic [TW-1:0] req0_tag;
    logic req1_valid, req1_ready;
    logic [DW-1:0] req1_a, req1_b;
    logic [TW-1:0] req1_tag;
    logic mult_en;
    logic [DW-1:0] mult_a, mult_b;
    logic [63:0] mult_result;
    logic res_valid;
    logic res_ready;
    logic res_id;
    logic [TW-1:0] res_tag;
    logic [63:0] res_data;
    logic busy;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;

    initial forever #5 clk = ~clk;

    int_mult_issue_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_STAGES (NS),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_tag    (req0_tag),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_tag    (req1_tag),
        .mult_en     (mult_en),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_result (mult_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_tag     (res_tag),
        .res_data    (res_data),
        .busy        (busy)
    );

    // Behavioural multiplier core: NS enabled register stages.
    logic [63:0] core_q [NS];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) core_q[i] <= '0;
        end else if (mult_en) begin
            core_q[0] <= 64'(mult_a) * 64'(mult_b);
            for (int i = 1; i < NS; i++) core_q[i] <= core_q[i-1];
        end
    end
    assign mult_result = core_q[NS-1];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic op_t mk(input logic [DW-1:0] a,
                               input logic [DW-1:0] b,
                               input logic [TW-1:0] t);
        op_t o;
        o.a = a;
        o.b = b;
        o.tag = t;
        return o;
    endfunction

    function automatic exp_t ex(input logic id, input logic [TW-1:0] t,
                                input logic [63:0] d);
        exp_t e;
        e.id = id;
        e.tag = t;
        e.data = d;
        return e;
    endfunction

    // Requester drivers: present queue heads, drop a head once taken.
    initial begin
        bit f0, f1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_tag = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_tag = 0;
        forever begin
            @(negedge clk);
            f0 = req0_valid && req0_ready;
            f1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (f0 && q0.size() != 0) q0.delete(0);
            if (f1 && q1.size() != 0) q1.delete(0);
            #2;
            if (q0.size() != 0) begin
                req0_valid = 1; req0_a = q0[0].a;
                req0_b = q0[0].b; req0_tag = q0[0].tag;
            end else begin
                req0_valid = 0; req0_a = 0; req0_b = 0; req0_tag = 0;
            end
            if (q1.size() != 0) begin
                req1_valid = 1; req1_a = q1[0].a;
                req1_b = q1[0].b; req1_tag = q1[0].tag;
            end else begin
                req1_valid = 0; req1_a = 0; req1_b = 0; req1_tag = 0;
            end
        end
    end

    // Result monitor: pop expected entry on every result handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
            end else begin
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got tag %0h data %0h expected none at %0t",
                                 res_tag, res_data, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_id", res_id, e.id);
                        chk("sb_tag", res_tag, e.tag);
                        chk("sb_data", res_data, e.data);
                    end
                end
                if (flush) sb.delete();
            end
        end
    end

    initial begin
        res_ready = 1;
        #12;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mult_en", mult_en, 1);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_mult_a", mult_a, 0);
        @(posedge clk);
        #2;
        rst_n = 1;
        tick();
        tick();

        // Contention: six ops, grants alternate starting with requester 0.
        q0.push_back(mk(5, 3, 0));
        q0.push_back(mk(11, 13, 2));
        q0.push_back(mk(100, 200, 4));
        q1.push_back(mk(2, 9, 1));
        q1.push_back(mk(17, 19, 3));
        q1.push_back(mk(65536, 65536, 5));
        sb.push_back(ex(0, 0, 64'd15));
        sb.push_back(ex(1, 1, 64'd18));
        sb.push_back(ex(0, 2, 64'd143));
        sb.push_back(ex(1, 3, 64'd323));
        sb.push_back(ex(0, 4, 64'd20000));
        sb.push_back(ex(1, 5, 64'h1_0000_0000));
        for (int c = 0; c < 12; c++) begin
            smp();
            if (c < 6) chk("cont_gnt0", req0_ready, (c % 2) == 0);
            if (c < 6) chk("cont_gnt1", req1_ready, (c % 2) == 1);
            chk("cont_res_valid", res_valid, (c >= 5) && (c <= 10));
            tick();
        end
        tick();

        // Single op: 7*6 tag 3, five-cycle latency.
        q0.push_back(mk(7, 6, 3));
        sb.push_back(ex(0, 3, 64'd42));
        for (int c = 0; c < 7; c++) begin
            smp();
            if (c == 0) chk("single_ready", req0_ready, 1);
            chk("single_res_valid", res_valid, c == 5);
            if (c == 6) chk("single_busy", busy, 0);
            tick();
        end
        tick();

        // Bubbles: issue at 0,2,3 gives results at 5,7,8.
        for (int c = 0; c < 11; c++) begin
            if (c == 0) begin
                q0.push_back(mk(3, 4, 1));
                sb.push_back(ex(0, 1, 64'd12));
            end
            if (c == 2) begin
                q0.push_back(mk(8, 9, 2));
                sb.push_back(ex(0, 2, 64'd72));
            end
            if (c == 3) begin
                q0.push_back(mk(10, 10, 5));
                sb.push_back(ex(0, 5, 64'd100));
            end
            smp();
            chk("bubble_res_valid", res_valid,
                (c == 5) || (c == 7) || (c == 8));
            tick();
        end
        tick();

        // Backpressure: stall four cycles with three ops in flight.
        q1.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 9));
        q1.push_back(mk(123456, 1000, 10));
        q1.push_back(mk(0, 99, 11));
        sb.push_back(ex(1, 9, 64'hFFFF_FFFE_0000_0001));
        sb.push_back(ex(1, 10, 64'd123456000));
        sb.push_back(ex(1, 11, 64'd0));
        for (int c = 0; c < 16; c++) begin
            if (c == 5) begin
                res_ready = 0;
                q0.push_back(mk(6, 7, 12));
                sb.push_back(ex(0, 12, 64'd42));
            end
            if (c == 9) res_ready = 1;
            smp();
            if (c >= 5 && c <= 8) begin
                chk("bp_mult_en", mult_en, 0);
                chk("bp_res_valid", res_valid, 1);
                chk("bp_res_data", res_data, 64'hFFFF_FFFE_0000_0001);
                chk("bp_res_tag", res_tag, 9);
                chk("bp_req0_ready", req0_ready, 0);
            end
            if (c == 9) chk("bp_release_ready", req0_ready, 1);
            if (c >= 9) chk("bp_drain_valid", res_valid,
                            (c >= 9 && c <= 11) || (c == 14));
            tick();
        end
        chk("bp_sb_empty", sb.size(), 0);
        chk("bp_busy", busy, 0);
        tick();

        // Flush: kill four in-flight ops, then one req1 op.
        for (int c = 0; c < 12; c++) begin
            if (c == 0) begin
                for (int k = 1; k <= 4; k++) begin
                    q0.push_back(mk(k, k, TW'(k)));
                    sb.push_back(ex(0, TW'(k), 64'(k * k)));
                end
            end
            if (c == 4) begin
                flush = 1;
                q1.push_back(mk(1000, 1000, 7));
            end
            if (c == 5) begin
                flush = 0;
                sb.push_back(ex(1, 7, 64'd1000000));
            end
            smp();
            if (c == 4) begin
                chk("flush_req1_ready", req1_ready, 0);
                chk("flush_mult_a", mult_a, 0);
                chk("flush_busy_before", busy, 1);
            end
            if (c == 5) begin
                chk("flush_busy", busy, 0);
                chk("flush_req1_after", req1_ready, 1);
            end
            if (c >= 4) chk("flush_res_valid", res_valid, c == 10);
            tick();
        end
        tick();

        // Reset mid-stream with a stalled result.
        for (int c = 0; c < 17; c++) begin
            if (c == 0) begin
                q0.push_back(mk(2, 3, 1));
                q0.push_back(mk(4, 5, 2));
                q0.push_back(mk(6, 7, 3));
                sb.push_back(ex(0, 1, 64'd6));
                sb.push_back(ex(0, 2, 64'd20));
                sb.push_back(ex(0, 3, 64'd42));
            end
            if (c == 5) res_ready = 0;
            if (c == 6) begin
                rst_n = 0;
                q0.delete();
                q1.delete();
            end
            if (c == 7) begin
                rst_n = 1;
                res_ready = 1;
            end
            if (c == 8) begin
                q0.push_back(mk(9, 9, 4));
                q1.push_back(mk(8, 8, 5));
                sb.push_back(ex(0, 4, 64'd81));
                sb.push_back(ex(1, 5, 64'd64));
            end
            smp();
            if (c == 5) chk("rstm_stalled", mult_en, 0);
            if (c == 6) begin
                chk("rstm_res_valid", res_valid, 0);
                chk("rstm_busy", busy, 0);
                chk("rstm_mult_en", mult_en, 1);
                chk("rstm_res_tag", res_tag, 0);
                chk("rstm_res_id", res_id, 0);
            end
            if (c == 8) begin
                chk("rstm_gnt0", req0_ready, 1);
                chk("rstm_gnt1", req1_ready, 0);
            end
            if (c == 9) chk("rstm_gnt1_next", req1_ready, 1);
            if (c >= 8) chk("rstm_res_valid_post", res_valid,
                            (c == 13) || (c == 14));
            tick();
        end
        chk("final_sb_empty", sb.size(), 0);
        chk("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
